// File: rtl/pontos_bcd_display.sv
// pontos_bcd_display: converts the binary score into BCD digits and
// active-low 7-segment patterns for the HEX displays. It performs one
// double-dabble (shift-add-3) step per clock and restarts by itself
// whenever the sampled score differs from the last converted value.
module pontos_bcd_display #(
   parameter int N           = 10,
   parameter int D           = 4,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input  logic             clock,
   input  logic             zera_s,
   input  logic [N-1:0]     pontos,
   output logic [4*D-1:0]   bcd,
   output logic [7*D-1:0]   seg,
   output logic             ocupado,
   output logic             pronto
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [N-1:0]    bin_r;
   logic [N-1:0]    cap_r;
   logic [N-1:0]    ultimo_r;
   logic [4*D-1:0]  work_r;
   logic [4*D-1:0]  work_adj_s;
   logic [CW-1:0]   step_r;
   logic [4*D-1:0]  bcd_r;
   logic [7*D-1:0]  seg_r;
   logic            ocupado_r;
   logic            pronto_r;
   logic            start_s;
   logic            step_s;
   logic            commit_s;

   // Add 3 to a single BCD nibble when it is 5 or more.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      logic [3:0] r;
      if (nib >= 4'd5) begin
         r = nib + 4'd3;
      end else begin
         r = nib;
      end
      return r;
   endfunction

   // Apply the add-3 correction to every nibble of the working register.
   function automatic logic [4*D-1:0] adjust(input logic [4*D-1:0] v);
      logic [4*D-1:0] r;
      r = {(4*D){1'b0}};
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = add3(v[4*i +: 4]);
      end
      return r;
   endfunction

   // One decimal digit to an active-low gfedcba pattern; invalid codes blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] r;
      case (d)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         default: r = 7'b1111111;
      endcase
      return r;
   endfunction

   // All digit patterns, blanking leading zeros above the units digit.
   function automatic logic [7*D-1:0] seg_all(input logic [4*D-1:0] v);
      logic [7*D-1:0] r;
      logic           lead;
      r    = {(7*D){1'b1}};
      lead = 1'b1;
      for (int i = D - 1; i >= 0; i--) begin
         if (v[4*i +: 4] != 4'd0) begin
            lead = 1'b0;
         end else begin
            lead = lead;
         end
         if (BLANK_ZEROS && lead && (i != 0)) begin
            r[7*i +: 7] = 7'b1111111;
         end else begin
            r[7*i +: 7] = seg7(v[4*i +: 4]);
         end
      end
      return r;
   endfunction

   assign work_adj_s = adjust(work_r);

   // State register.
   always_ff @(posedge clock) begin
      if (zera_s) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: capture on a new score, N shift steps, one commit cycle.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (pontos != ultimo_r) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (step_r == LAST_STEP) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state.
   always_comb begin
      start_s  = 1'b0;
      step_s   = 1'b0;
      commit_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (pontos != ultimo_r) begin
               start_s = 1'b1;
            end else begin
               start_s = 1'b0;
            end
         end
         SHIFT:   step_s   = 1'b1;
         DONE:    commit_s = 1'b1;
         default: start_s  = 1'b0;
      endcase
   end

   // Working registers, held outputs and status flags.
   always_ff @(posedge clock) begin
      if (zera_s) begin
         bin_r     <= {N{1'b0}};
         cap_r     <= {N{1'b0}};
         ultimo_r  <= {N{1'b0}};
         work_r    <= {(4*D){1'b0}};
         step_r    <= {CW{1'b0}};
         bcd_r     <= {(4*D){1'b0}};
         seg_r     <= seg_all({(4*D){1'b0}});
         ocupado_r <= 1'b0;
         pronto_r  <= 1'b0;
      end else begin
         ocupado_r <= (state_next_s != IDLE);
         pronto_r  <= commit_s;
         if (start_s) begin
            bin_r  <= pontos;
            cap_r  <= pontos;
            work_r <= {(4*D){1'b0}};
            step_r <= {CW{1'b0}};
         end else if (step_s) begin
            {work_r, bin_r} <= {work_adj_s[4*D-2:0], bin_r, 1'b0};
            step_r          <= step_r + {{(CW-1){1'b0}}, 1'b1};
         end else if (commit_s) begin
            bcd_r    <= work_r;
            seg_r    <= seg_all(work_r);
            ultimo_r <= cap_r;
         end
      end
   end

   assign bcd     = bcd_r;
   assign seg     = seg_r;
   assign ocupado = ocupado_r;
   assign pronto  = pronto_r;

endmodule

// File: tb/tb_pontos_bcd_display.sv
// Directed testbench for pontos_bcd_display (N=10, D=4), with one instance
// blanking leading zeros and one showing all digits.
module tb_pontos_bcd_display;

   localparam int N = 10;
   localparam int D = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;

   logic             clock = 1'b0;
   logic             zera_s;
   logic [N-1:0]     pontos;
   logic [4*D-1:0]   bcd, bcd_nb;
   logic [7*D-1:0]   seg, seg_nb;
   logic             ocupado, ocupado_nb;
   logic             pronto, pronto_nb;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pontos_bcd_display #(.N(N), .D(D), .BLANK_ZEROS(1'b1)) dut (
      .clock(clock), .zera_s(zera_s), .pontos(pontos),
      .bcd(bcd), .seg(seg), .ocupado(ocupado), .pronto(pronto)
   );

   pontos_bcd_display #(.N(N), .D(D), .BLANK_ZEROS(1'b0)) dut_nb (
      .clock(clock), .zera_s(zera_s), .pontos(pontos),
      .bcd(bcd_nb), .seg(seg_nb), .ocupado(ocupado_nb), .pronto(pronto_nb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Tick until pronto is seen or the bound expires; n = ticks taken.
   task automatic wait_pronto(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!pronto && n < 40);
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int          x;
      r = 32'd0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   initial begin
      int n;
      int npr;
      int nocu;
      int n_pronto;
      logic [N-1:0] pre;
      logic [N-1:0] cap;
      logic         ocu_prev;

      // Reset with pontos = 0
      zera_s = 1'b1;
      pontos = 10'd0;
      tick();
      tick();
      zera_s = 1'b0;
      check("rst_bcd", 32'(bcd), 32'h0000);
      check("rst_seg", 32'(seg), 32'({SB, SB, SB, S0}));
      check("rst_seg_nb", 32'(seg_nb), 32'({S0, S0, S0, S0}));
      npr  = 0;
      nocu = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pronto) npr++;
         if (ocupado) nocu++;
      end
      check("idle_pronto", 32'(npr), 32'd0);
      check("idle_ocupado", 32'(nocu), 32'd0);

      // 0 -> 999
      pontos = 10'd999;
      tick();
      check("999_ocupado", 32'(ocupado), 32'd1);
      wait_pronto(n);
      check("999_lat", 32'(n), 32'd11);
      check("999_bcd", 32'(bcd), 32'h0999);
      check("999_seg", 32'(seg), 32'({SB, S9, S9, S9}));
      check("999_ocupado_end", 32'(ocupado), 32'd0);
      tick();
      check("999_pulse", 32'(pronto), 32'd0);

      // 1023
      pontos = 10'd1023;
      wait_pronto(n);
      check("1023_lat", 32'(n), 32'd12);
      check("1023_bcd", 32'(bcd), 32'h1023);
      check("1023_seg", 32'(seg), 32'({S1, S0, S2, S3}));

      // 5, both blanking modes
      pontos = 10'd5;
      wait_pronto(n);
      check("5_lat", 32'(n), 32'd12);
      check("5_bcd", 32'(bcd), 32'h0005);
      check("5_seg", 32'(seg), 32'({SB, SB, SB, S5}));
      check("5_pronto_nb", 32'(pronto_nb), 32'd1);
      check("5_bcd_nb", 32'(bcd_nb), 32'h0005);
      check("5_seg_nb", 32'(seg_nb), 32'({S0, S0, S0, S5}));

      // 10 -> 11 one cycle after capture of 10
      pontos = 10'd10;
      tick();
      pontos = 10'd11;
      wait_pronto(n);
      check("10_lat", 32'(n), 32'd11);
      check("10_bcd", 32'(bcd), 32'h0010);
      tick();
      check("11_start_pronto", 32'(pronto), 32'd0);
      check("11_start_ocupado", 32'(ocupado), 32'd1);
      wait_pronto(n);
      check("11_lat", 32'(n), 32'd11);
      check("11_bcd", 32'(bcd), 32'h0011);

      // Reset at iteration 5 of converting 512
      pontos = 10'd512;
      tick();
      repeat (4) tick();
      check("512_busy", 32'(ocupado), 32'd1);
      zera_s = 1'b1;
      tick();
      zera_s = 1'b0;
      check("512_rst_bcd", 32'(bcd), 32'h0000);
      check("512_rst_seg", 32'(seg), 32'({SB, SB, SB, S0}));
      check("512_rst_seg_nb", 32'(seg_nb), 32'({S0, S0, S0, S0}));
      check("512_rst_ocupado", 32'(ocupado), 32'd0);
      check("512_rst_pronto", 32'(pronto), 32'd0);
      wait_pronto(n);
      check("512_lat", 32'(n), 32'd12);
      check("512_bcd", 32'(bcd), 32'h0512);
      check("512_seg", 32'(seg), 32'({SB, S5, S1, S2}));

      // Sweep 0..1023, one increment every 13 cycles
      n_pronto = 0;
      ocu_prev = ocupado;
      cap      = '0;
      for (int v = 0; v < 1024; v++) begin
         pontos = 10'(v);
         for (int c = 0; c < 13; c++) begin
            pre = pontos;
            tick();
            if (ocupado && !ocu_prev) cap = pre;
            ocu_prev = ocupado;
            if (pronto) begin
               n_pronto++;
               check("sweep_bcd", 32'(bcd), to_bcd(int'(cap)));
            end
         end
      end
      check("sweep_count", 32'(n_pronto), 32'd1024);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pontos_bcd_display.md
# pontos_bcd_display

Read-side companion of the score counter: it samples the binary score register and converts it to BCD digits and active-low 7-segment patterns for the board's HEX displays. Conversion runs iteratively, one double-dabble (shift-add-3) step per clock. A new conversion starts automatically whenever the sampled score differs from the last converted value. The block sits between the score counter output and the top-level HEX pins.

## Interface

- N, 10, width of the binary score input
- D, 4, number of decimal digits produced; configuration rule: 10^D > 2^N − 1 (no overflow detection in hardware)
- BLANK_ZEROS, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits

- clock  in  1  system clock, rising edge
- zera_s  in  1  reset, synchronous, active-high; aborts any conversion in progress
- pontos  in  N  binary score, sampled only in IDLE
- bcd  out  4*D  converted digits; digit i at bits [4i+3:4i], digit 0 = units
- seg  out  7*D  7-segment patterns; digit i at bits [7i+6:7i]; bit 0 = a … bit 6 = g; active-low (0 = lit)
- ocupado  out  1  high while in SHIFT or DONE
- pronto  out  1  one-cycle pulse when bcd/seg update

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If pontos != ultimo (internal N-bit last-converted value): load pontos into the binary shift register, clear the 4*D-bit BCD working register, clear the step counter, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clock:
  - Every BCD nibble ≥ 5 gets +3, computed from the current register value.
  - Then {BCD, binary} shifts left by 1.
  - After the N-th iteration, go to DONE.
  - Step counter width is ceil(log2(N+1)).
- DONE, one clock:
  - Copy the working register to bcd.
  - Register seg from the new digits.
  - ultimo <= captured value.
  - pronto = 1, then go to IDLE.
- Digit encoding (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibble values > 9 never occur; encode them as blank (1111111).
- Blanking (BLANK_ZEROS=1):
  - Digit i ≥ 1 is blank (1111111) when it and all higher digits are 0.
  - Digit 0 always shows its value.
- pontos changing during SHIFT/DONE is ignored; the captured value completes. IDLE re-samples on the next edge, so the final value is always converted.
- Reset values:
  - state = IDLE; bcd = 0; ultimo = 0; pronto = 0; ocupado = 0.
  - seg: digit 0 = 1000000; other digits = 1111111 if BLANK_ZEROS, else 1000000.
- Reset in mid-conversion discards the working registers. If pontos ≠ 0 after reset, a fresh conversion starts.

## Timing

- Edge k: in IDLE with pontos != ultimo → capture, enter SHIFT.
- Edges k+1 … k+N: N shift iterations; the N-th edge enters DONE.
- Edge k+N+1: bcd, seg, ultimo updated; pronto high during the cycle after that edge; state IDLE.
- Latency from a sampled change to updated outputs: N+1 edges (11 for N=10). Minimum spacing between conversions: N+2 edges.
- ocupado is high in the cycles after edges k … k+N.
- bcd/seg are stable (held) between DONE updates; no glitches in IDLE/SHIFT.
- pronto never asserts twice without an intervening conversion.

## Test plan

- Reset with pontos=0:
  - seg = {1111111×3, 1000000}, bcd = 0x0000.
  - No pronto over 20 cycles; ocupado stays 0.
- pontos 0→999 held (N=10, D=4):
  - ocupado rises after the next edge.
  - After 11 edges: bcd = 0x0999, pronto pulses exactly one cycle.
  - seg = {1111111, 0010000, 0010000, 0010000}.
- pontos=1023:
  - bcd = 0x1023; seg digit3 = 1111001, digit2 = 1000000.
  - Repeat with BLANK_ZEROS=0 and pontos=5: bcd = 0x0005, digits 3..1 = 1000000.
- pontos 10→11 one cycle after the capture of 10:
  - First pronto shows bcd = 0x0010.
  - Second conversion starts on the following edge; second pronto shows 0x0011.
- Assert zera_s for one cycle at iteration 5 of converting 512:
  - Outputs return to reset values, no pronto.
  - Conversion restarts; pronto with bcd = 0x0512 arrives 12 edges after zera_s deasserts.
- Sweep pontos 0..1023 via a driving counter with inc pulses every 13 cycles:
  - Every pronto shows bcd equal to the decimal value of the score sampled at capture.
